// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - configuration-chain initiator: probes the chain length, then serialises the bitstream
module ccff_chain_loader #(
    parameter int         CHAIN_LEN = 1024,
    parameter int         WORD_W    = 8,
    parameter int         CNT_W     = 16,
    parameter logic [7:0] MARKER    = 8'hA5
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bit_count
);
    localparam int               BC_W          = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LP_LEN        = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LP_PROBE_LAST = CNT_W'(CHAIN_LEN + 7);
    localparam logic [CNT_W-1:0] LP_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_MK_BITS    = CNT_W'(8);
    localparam logic [BC_W-1:0]  LP_FULL       = BC_W'(WORD_W);
    localparam logic [BC_W-1:0]  LP_BC_ONE     = BC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_bit_count;
    logic [CNT_W-1:0]  w_bit_count_nxt;
    logic [WORD_W-1:0] r_buf;
    logic [WORD_W-1:0] w_buf_nxt;
    logic [BC_W-1:0]   r_cnt;
    logic [BC_W-1:0]   w_cnt_nxt;
    logic              r_head;
    logic              w_head_nxt;
    logic              r_shift_en;
    logic              w_shift_en_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_error;
    logic              w_error_nxt;

    logic [CNT_W-1:0]  w_inc;
    logic [2:0]        w_probe_idx;
    logic [2:0]        w_head_idx;
    logic              w_buf_has;
    logic              w_ready;
    logic              w_accept;

    // Marker bits go out MSB first, so bit index is 7 minus the offset (bitwise NOT of 3 bits).
    assign w_inc       = r_bit_count + LP_ONE;
    assign w_probe_idx = ~3'(r_bit_count - LP_LEN);
    assign w_head_idx  = ~3'(w_inc);
    assign w_buf_has   = (r_cnt != '0);
    assign w_ready     = (r_state == S_LOAD) && (r_cnt <= LP_BC_ONE);
    assign w_accept    = w_ready && word_valid;

    assign word_ready = w_ready;
    assign ccff_head  = r_head;
    assign shift_en   = r_shift_en;
    assign busy       = (r_state == S_PROBE) || (r_state == S_LOAD);
    assign done       = r_done;
    assign error      = r_error;
    assign bit_count  = r_bit_count;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state     <= S_IDLE;
            r_bit_count <= '0;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_count <= w_bit_count_nxt;
            r_buf       <= w_buf_nxt;
            r_cnt       <= w_cnt_nxt;
            r_head      <= w_head_nxt;
            r_shift_en  <= w_shift_en_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
        end
    end

    // Head and shift enable are computed one cycle ahead so the chain sees flop outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_count_nxt = r_bit_count;
        w_buf_nxt       = r_buf;
        w_cnt_nxt       = r_cnt;
        w_head_nxt      = r_head;
        w_shift_en_nxt  = 1'b0;
        w_done_nxt      = r_done;
        w_error_nxt     = r_error;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nxt     = S_PROBE;
                    w_bit_count_nxt = '0;
                    w_cnt_nxt       = '0;
                    w_head_nxt      = MARKER[7];
                    w_shift_en_nxt  = 1'b1;
                    w_done_nxt      = 1'b0;
                    w_error_nxt     = 1'b0;
                end
            end
            S_PROBE: begin
                if ((r_bit_count >= LP_LEN) && (ccff_tail != MARKER[w_probe_idx])) begin
                    w_state_nxt = S_ERR;
                    w_error_nxt = 1'b1;
                end else if (r_bit_count == LP_PROBE_LAST) begin
                    w_state_nxt     = S_LOAD;
                    w_bit_count_nxt = '0;
                    w_head_nxt      = 1'b0;
                end else begin
                    w_bit_count_nxt = w_inc;
                    w_shift_en_nxt  = 1'b1;
                    w_head_nxt      = (w_inc < LP_MK_BITS) ? MARKER[w_head_idx] : 1'b0;
                end
            end
            S_LOAD: begin
                if (w_buf_has) begin
                    w_bit_count_nxt = w_inc;
                    w_buf_nxt       = r_buf << 1;
                    w_cnt_nxt       = r_cnt - LP_BC_ONE;
                end
                if (w_accept) begin
                    w_buf_nxt = word_data;
                    w_cnt_nxt = LP_FULL;
                end
                if (w_buf_has && (w_inc == LP_LEN)) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_nxt != '0) begin
                    w_shift_en_nxt = 1'b1;
                    w_head_nxt     = w_buf_nxt[WORD_W-1];
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - vector table, hand sequences and randomised runs against a bit-stream chain model
module tb_ccff_chain_loader;
    localparam int         LEN_A = 16;
    localparam int         LEN_B = 12;
    localparam logic [7:0] MK    = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a, valid_a, ready_a, head_a, tail_a, sen_a, busy_a, done_a, err_a;
    logic [7:0]  data_a;
    logic [15:0] cnt_a;
    logic        start_b, valid_b, ready_b, head_b, tail_b, sen_b, busy_b, done_b, err_b;
    logic [7:0]  data_b;
    logic [15:0] cnt_b;

    ccff_chain_loader #(.CHAIN_LEN(LEN_A), .WORD_W(8), .CNT_W(16), .MARKER(MK)) u_dut_a (
        .prog_clk(clk), .pReset(rst), .start(start_a),
        .word_data(data_a), .word_valid(valid_a), .word_ready(ready_a),
        .ccff_head(head_a), .ccff_tail(tail_a), .shift_en(sen_a),
        .busy(busy_a), .done(done_a), .error(err_a), .bit_count(cnt_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(LEN_B), .WORD_W(8), .CNT_W(16), .MARKER(MK)) u_dut_b (
        .prog_clk(clk), .pReset(rst), .start(start_b),
        .word_data(data_b), .word_valid(valid_b), .word_ready(ready_b),
        .ccff_head(head_b), .ccff_tail(tail_b), .shift_en(sen_b),
        .busy(busy_b), .done(done_b), .error(err_b), .bit_count(cnt_b)
    );

    // Chain model: gated shift register, first bit in ends up at the tail end.
    logic [63:0] chain_a = '0;
    logic [63:0] chain_b = '0;
    int          phys_len_a = LEN_A;
    assign tail_a = chain_a[6'(phys_len_a - 1)];
    assign tail_b = chain_b[LEN_B-1];
    always @(posedge clk) begin
        if (sen_a) chain_a <= {chain_a[62:0], head_a};
        if (sen_b) chain_b <= {chain_b[62:0], head_b};
    end

    typedef struct {
        logic [7:0]  w0;
        logic [7:0]  w1;
        int          stall;
        logic [15:0] exp_chain;
        int          exp_gap;
    } vec_t;
    vec_t tbl[4];

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] word_q[$];
    logic       bits[$];
    int         r_cyc, r_nload, r_gap, r_probe_ready, r_accepted;
    logic [15:0] exp_c;
    logic [7:0] qb[2];
    int         ib, nsen_b, late_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One start-to-finish pass on DUT A; expected load bits come from the accepted word stream.
    task automatic run_a(input int stall, input int pct, input bit poke, input bit rst_mid);
        int         i, held, en, first, last, cyc;
        logic [7:0] mk;
        logic [7:0] w;
        mk = MK; i = 0; held = 0; en = 0; first = -1; last = -1;
        r_nload = 0; r_probe_ready = 0; bits.delete();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        check("start_enters_probe", 64'({done_a, err_a, busy_a, sen_a, cnt_a}), 64'({4'b0011, 16'd0}));
        for (cyc = 0; cyc < 400; cyc++) begin
            if (done_a || err_a) break;
            start_a = poke && (cyc == 5 || cyc == LEN_A + 14);
            if (poke && cyc == 6) check("probe_ignores_start", 64'(cnt_a), 64'(6));
            if (poke && cyc == LEN_A + 15) check("load_ignores_start", 64'(cnt_a), 64'(6));
            if (rst_mid && en >= LEN_A + 8 && cnt_a == 16'd7) begin
                #2 rst = 1'b1;
                #1;
                check("async_reset_outputs",
                      64'({head_a, sen_a, ready_a, busy_a, done_a, err_a, cnt_a}), 64'(0));
                break;
            end
            if (busy_a && en < LEN_A + 8 && ready_a) r_probe_ready++;
            if (sen_a) begin
                if (en >= LEN_A + 8) begin
                    check("load_head_bit", 64'(head_a),
                          64'((r_nload < bits.size()) ? bits[r_nload] : 1'bx));
                    if (first < 0) first = cyc;
                    last = cyc;
                    r_nload++;
                end else if (phys_len_a == LEN_A && en >= LEN_A) begin
                    check("probe_tail_marker", 64'(tail_a), 64'(mk[7 - (en - LEN_A)]));
                end
                en++;
            end
            valid_a = 1'b0;
            if (i < word_q.size()) begin
                if (ready_a && i == 1 && held < stall) begin
                    held++;
                end else if ($urandom_range(99) < pct) begin
                    valid_a = 1'b1;
                    data_a  = word_q[i];
                    if (ready_a) begin
                        w = word_q[i];
                        for (int b = 7; b >= 0; b--) bits.push_back(w[b]);
                        i++;
                    end
                end
            end
            @(negedge clk);
        end
        start_a    = 1'b0;
        valid_a    = 1'b0;
        r_cyc      = cyc;
        r_gap      = (first < 0) ? -1 : (last - first + 1 - r_nload);
        r_accepted = i;
    endtask

    task automatic expect_done(input string tag, input logic [15:0] chain_exp);
        check({tag, "_flags"}, 64'({done_a, err_a, busy_a, sen_a, ready_a}), 64'(5'b10000));
        check({tag, "_chain"}, 64'(chain_a[15:0]), 64'(chain_exp));
        check({tag, "_bits_shifted"}, 64'(r_nload), 64'(LEN_A));
        check({tag, "_bit_count"}, 64'(cnt_a), 64'(LEN_A));
        check({tag, "_probe_no_ready"}, 64'(r_probe_ready), 64'(0));
    endtask

    initial begin
        tbl[0] = '{8'hFF, 8'h00, 0, 16'hFF00, 0};
        tbl[1] = '{8'hFF, 8'h00, 5, 16'hFF00, 5};
        tbl[2] = '{8'hA5, 8'h3C, 3, 16'hA53C, 3};
        tbl[3] = '{8'h01, 8'h80, 1, 16'h0180, 1};
        start_a = 1'b0; valid_a = 1'b0; data_a = '0;
        start_b = 1'b0; valid_b = 1'b0; data_b = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_a", 64'({head_a, sen_a, ready_a, busy_a, done_a, err_a, cnt_a}), 64'(0));
        check("reset_b", 64'({head_b, sen_b, ready_b, busy_b, done_b, err_b, cnt_b}), 64'(0));
        rst = 1'b0;

        for (int t = 0; t < 4; t++) begin
            word_q = {tbl[t].w0, tbl[t].w1, 8'h5A, 8'hC3};
            run_a(tbl[t].stall, 100, 1'b0, 1'b0);
            expect_done("tbl", tbl[t].exp_chain);
            check("tbl_stall_gap", 64'(r_gap), 64'(tbl[t].exp_gap));
        end

        word_q = {8'hFF, 8'h00, 8'h11, 8'h22};
        run_a(0, 100, 1'b1, 1'b0);
        expect_done("poke", 16'hFF00);

        phys_len_a = LEN_A - 1;
        word_q = {8'hFF, 8'h00};
        run_a(0, 100, 1'b0, 1'b0);
        check("short_chain_flags", 64'({done_a, err_a, busy_a, sen_a, ready_a}), 64'(5'b01000));
        check("short_chain_latency", 64'(r_cyc <= LEN_A + 8), 64'(1));
        check("short_chain_no_ready", 64'(r_probe_ready), 64'(0));
        check("short_chain_no_accept", 64'(r_accepted), 64'(0));
        phys_len_a = LEN_A;

        for (int r = 0; r < 6; r++) begin
            word_q.delete();
            for (int k = 0; k < 4; k++) word_q.push_back(8'($urandom));
            run_a(0, 40 + 10 * r, 1'b0, 1'b0);
            exp_c = '0;
            for (int k = 0; k < LEN_A; k++) exp_c = {exp_c[14:0], (k < bits.size()) ? bits[k] : 1'bx};
            expect_done("rnd", exp_c);
        end

        word_q = {8'h3C, 8'h96, 8'h0F, 8'hF0};
        run_a(0, 100, 1'b0, 1'b1);
        check("rst_mid_reached", 64'(rst), 64'(1));
        repeat (2) @(negedge clk);
        check("rst_mid_held", 64'({busy_a, done_a, err_a, cnt_a}), 64'(0));
        rst = 1'b0;
        run_a(0, 100, 1'b0, 1'b0);
        expect_done("after_rst", 16'h3C96);

        qb = '{8'hAB, 8'hCD};
        ib = 0; nsen_b = 0; late_ready = 0;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (done_b || err_b) break;
            if (sen_b) nsen_b++;
            if (ib == 2 && ready_b) late_ready++;
            valid_b = 1'b0;
            if (ib < 2) begin
                valid_b = 1'b1;
                data_b  = qb[ib];
                if (ready_b) ib++;
            end
            @(negedge clk);
        end
        valid_b = 1'b0;
        check("len12_flags", 64'({done_b, err_b, busy_b}), 64'(3'b100));
        check("len12_chain", 64'(chain_b[11:0]), 64'(12'hABC));
        check("len12_ready_drops", 64'(late_ready), 64'(0));
        check("len12_words", 64'(ib), 64'(2));
        check("len12_enabled_cycles", 64'(nsen_b), 64'(LEN_B + 8 + LEN_B));
        check("len12_bit_count", 64'(cnt_b), 64'(LEN_B));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
